pll_sweep_ctrl: RTL

Parametrised successor to the memtest frequency stepper. It owns a PLL reconfiguration sequencer that walks an external frequency table through the PLL reconfig management port, and an auto-sweep engine that advances on clean test rounds and records the highest passing entry. It also keeps a BCD elapsed-time counter for the OSD. It sits between the hps_io/key decoder, the `pll_cfg` management port and the SDRAM tester in the CLK_50M domain.

---
 rtl/pll_sweep_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/pll_sweep_ctrl.sv
// pll_sweep_ctrl: PLL reconfiguration sequencer with auto frequency sweep
// and a BCD elapsed-time counter for the memtest OSD.
module pll_sweep_ctrl #(
  parameter int ENTRIES = 38,
  parameter int POS_W   = 6,
  parameter int SLOT    = 8,
  parameter int CLK_HZ  = 50_000_000,
  parameter int LOCK_TO = 1_000_000,
  parameter int DIGITS  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_up,
  input  logic                  cmd_down,
  input  logic                  cmd_retry,
  input  logic                  cmd_auto,
  input  logic                  cmd_stop,
  input  logic                  stop_on_fail,
  input  logic                  round_done,
  input  logic                  round_err,
  output logic [POS_W-1:0]      tbl_idx,
  input  logic [31:0]           tbl_m,
  input  logic [31:0]           tbl_k,
  input  logic [31:0]           tbl_c,
  output logic [5:0]            mgmt_address,
  output logic [31:0]           mgmt_writedata,
  output logic                  mgmt_write,
  input  logic                  mgmt_waitrequest,
  input  logic                  locked,
  output logic                  pll_reset,
  output logic                  recfg,
  output logic [POS_W-1:0]      pos,
  output logic                  auto,
  output logic [POS_W-1:0]      best_pos,
  output logic                  best_valid,
  output logic                  lock_fail,
  output logic [4*DIGITS-1:0]   mins,
  output logic [7:0]            secs
);

  localparam int CW = $clog2(SLOT + 1);
  localparam int LW = $clog2(LOCK_TO + 1);
  localparam int TW = $clog2(CLK_HZ + 1);
  localparam int MW = 4 * DIGITS;
  localparam logic [POS_W-1:0] TOP = POS_W'(ENTRIES - 1);

  typedef enum logic [2:0] {IDLE, WR, PRST, PREL, LOCKW, RUN} state_t;

  state_t            state_q, state_d;
  logic [2:0]        slot_q, slot_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [LW-1:0]     tmr_q, tmr_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic              auto_q, auto_d;
  logic [POS_W-1:0]  best_pos_q, best_pos_d;
  logic              best_valid_q, best_valid_d;
  logic              lock_fail_q, lock_fail_d;
  logic              recfg_q, recfg_d;
  logic              pll_reset_q, pll_reset_d;
  logic              mw_q, mw_d;
  logic [5:0]        maddr_q, maddr_d;
  logic [31:0]       mdata_q, mdata_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [5:0]        sixty_q, sixty_d;
  logic [7:0]        secs_q, secs_d;
  logic [MW-1:0]     mins_q, mins_d;

  logic              up_ok, dn_ok, cmd_hit;
  logic              reconf, evt, evt_err;
  logic [5:0]        wa;
  logic [31:0]       wd;

  function automatic logic [MW-1:0] bcd_inc(input logic [MW-1:0] v);
    logic [MW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Reconfig write list, one entry per slot
  always_comb begin
    wa = 6'd0;
    wd = 32'd0;
    case (slot_q)
      3'd0: begin wa = 6'd0; wd = 32'd0;       end
      3'd1: begin wa = 6'd4; wd = tbl_m;       end
      3'd2: begin wa = 6'd7; wd = tbl_k;       end
      3'd3: begin wa = 6'd3; wd = 32'h10000;   end
      3'd4: begin wa = 6'd5; wd = tbl_c;       end
      3'd5: begin wa = 6'd9; wd = 32'd1;       end
      3'd6: begin wa = 6'd8; wd = 32'd7;       end
      3'd7: begin wa = 6'd2; wd = 32'd0;       end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    cnt_d        = cnt_q;
    tmr_d        = tmr_q;
    pos_d        = pos_q;
    auto_d       = auto_q;
    best_pos_d   = best_pos_q;
    best_valid_d = best_valid_q;
    lock_fail_d  = lock_fail_q;
    recfg_d      = recfg_q;
    pll_reset_d  = pll_reset_q;
    mw_d         = 1'b0;
    maddr_d      = maddr_q;
    mdata_d      = mdata_q;
    tick_d       = tick_q;
    sixty_d      = sixty_q;
    secs_d       = secs_q;
    mins_d       = mins_q;
    reconf       = 1'b0;
    evt          = 1'b0;
    evt_err      = 1'b0;

    up_ok   = cmd_up && !cmd_down && (pos_q < TOP);
    dn_ok   = cmd_down && !cmd_up && (pos_q != '0);
    cmd_hit = cmd_stop | cmd_auto | cmd_retry | up_ok | dn_ok;

    unique case (state_q)
      WR: begin
        if (cnt_q == '0) begin
          if (!mgmt_waitrequest) begin
            mw_d    = 1'b1;
            maddr_d = wa;
            mdata_d = wd;
            cnt_d   = CW'(1);
          end
        end else if (cnt_q == CW'(SLOT - 1)) begin
          cnt_d = '0;
          if (slot_q == 3'd7) state_d = PRST;
          else slot_d = slot_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PRST: begin
        if (cnt_q == '0) pll_reset_d = 1'b1;
        if (cnt_q == CW'(SLOT)) begin
          pll_reset_d = 1'b0;
          cnt_d       = '0;
          state_d     = PREL;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PREL: begin
        tmr_d   = '0;
        state_d = LOCKW;
      end
      LOCKW: begin
        if (locked) begin
          state_d     = RUN;
          recfg_d     = 1'b0;
          lock_fail_d = 1'b0;
        end else if (tmr_q == LW'(LOCK_TO - 1)) begin
          state_d     = RUN;
          recfg_d     = 1'b0;
          lock_fail_d = 1'b1;
          evt         = 1'b1;
          evt_err     = 1'b1;
        end else begin
          tmr_d = tmr_q + LW'(1);
        end
      end
      RUN: begin
        evt     = round_done;
        evt_err = round_err;
      end
      default: ;
    endcase

    // Sweep step; a coincident command discards the round
    if (evt && auto_q && !cmd_hit) begin
      if (evt_err && stop_on_fail) begin
        auto_d = 1'b0;
      end else begin
        if (!evt_err) begin
          best_pos_d   = pos_q;
          best_valid_d = 1'b1;
        end
        if (pos_q < TOP) begin
          pos_d  = pos_q + POS_W'(1);
          reconf = 1'b1;
        end else begin
          auto_d = 1'b0;
        end
      end
    end

    if (cmd_stop) begin
      auto_d = 1'b0;
    end else if (cmd_auto) begin
      pos_d        = '0;
      auto_d       = 1'b1;
      best_valid_d = 1'b0;
      reconf       = 1'b1;
    end else if (cmd_retry) begin
      auto_d = 1'b0;
      reconf = 1'b1;
    end else if (up_ok) begin
      pos_d  = pos_q + POS_W'(1);
      auto_d = 1'b0;
      reconf = 1'b1;
    end else if (dn_ok) begin
      pos_d  = pos_q - POS_W'(1);
      auto_d = 1'b0;
      reconf = 1'b1;
    end

    if (reconf) begin
      state_d     = WR;
      slot_d      = '0;
      cnt_d       = '0;
      recfg_d     = 1'b1;
      pll_reset_d = 1'b0;
      mw_d        = 1'b0;
    end

    if (recfg_q) begin
      tick_d  = '0;
      sixty_d = '0;
      secs_d  = '0;
      mins_d  = '0;
    end else if (tick_q == TW'(CLK_HZ - 1)) begin
      tick_d = '0;
      secs_d = secs_q + 8'd1;
      if (sixty_q == 6'd59) begin
        sixty_d = '0;
        mins_d  = bcd_inc(mins_q);
      end else begin
        sixty_d = sixty_q + 6'd1;
      end
    end else begin
      tick_d = tick_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= WR;
      slot_q       <= '0;
      cnt_q        <= '0;
      tmr_q        <= '0;
      pos_q        <= '0;
      auto_q       <= 1'b1;
      best_pos_q   <= '0;
      best_valid_q <= 1'b0;
      lock_fail_q  <= 1'b0;
      recfg_q      <= 1'b1;
      pll_reset_q  <= 1'b0;
      mw_q         <= 1'b0;
      maddr_q      <= '0;
      mdata_q      <= '0;
      tick_q       <= '0;
      sixty_q      <= '0;
      secs_q       <= '0;
      mins_q       <= '0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      cnt_q        <= cnt_d;
      tmr_q        <= tmr_d;
      pos_q        <= pos_d;
      auto_q       <= auto_d;
      best_pos_q   <= best_pos_d;
      best_valid_q <= best_valid_d;
      lock_fail_q  <= lock_fail_d;
      recfg_q      <= recfg_d;
      pll_reset_q  <= pll_reset_d;
      mw_q         <= mw_d;
      maddr_q      <= maddr_d;
      mdata_q      <= mdata_d;
      tick_q       <= tick_d;
      sixty_q      <= sixty_d;
      secs_q       <= secs_d;
      mins_q       <= mins_d;
    end
  end

  assign tbl_idx        = pos_q;
  assign pos            = pos_q;
  assign auto           = auto_q;
  assign best_pos       = best_pos_q;
  assign best_valid     = best_valid_q;
  assign lock_fail      = lock_fail_q;
  assign recfg          = recfg_q;
  assign pll_reset      = pll_reset_q;
  assign mgmt_write     = mw_q;
  assign mgmt_address   = maddr_q;
  assign mgmt_writedata = mdata_q;
  assign mins           = mins_q;
  assign secs           = secs_q;

endmodule
